// File: rtl/ckt_pkg.sv
// Shared constants and the reference evaluation of the ckt logic cone.
package ckt_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam int          RESP_W    = 4;

  // Returns the response word {n1,n2,n3,w} for one test vector.
  function automatic logic [RESP_W-1:0] ckt_eval(input logic a, input logic b,
                                                 input logic c, input logic d,
                                                 input logic e, input logic f);
    logic n1, n2, n3, n4, wn;
    n1 = a & b;
    n2 = c & d;
    n3 = e | f;
    n4 = n1 | n2;
    wn = n4 ^ n3;
    return {n1, n2, n3, wn};
  endfunction

endpackage

// File: rtl/ckt_if.sv
// Vector/response bundle between a tester and the ckt circuit-under-test.
interface ckt_if
  import ckt_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
);
  logic             in_valid;
  logic             a, b, c, d, e, f;
  logic             sig_clr;
  logic             w;
  logic             w_valid;
  logic [SIG_W-1:0] sig;

  modport master (
    output in_valid, a, b, c, d, e, f, sig_clr,
    input  w, w_valid, sig
  );

  modport slave (
    input  in_valid, a, b, c, d, e, f, sig_clr,
    output w, w_valid, sig
  );
endinterface

// File: rtl/ckt_misr.sv
// Multiple-input signature register compacting the 4-bit response word.
module ckt_misr
  import ckt_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                 input logic [RESP_W-1:0] resp);
    return {cur[SIG_W-2:0], 1'b0} ^ (cur[SIG_W-1] ? POLY : {SIG_W{1'b0}})
           ^ SIG_W'(resp);
  endfunction

  // Clear wins over a same-cycle update, so that vector is dropped.
  always_comb begin
    w_sig_next = r_sig;
    if (clr) begin
      w_sig_next = {SIG_W{1'b0}};
    end else if (en) begin
      w_sig_next = misr_step(r_sig, din);
    end else begin
      w_sig_next = r_sig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= {SIG_W{1'b0}};
    end else begin
      r_sig <= w_sig_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/ckt.sv
// Two-stage circuit-under-test: registered inputs, a named-net logic cone and
// registered outputs feeding the response compactor.
module ckt
  import ckt_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic  clk,
  input  logic  rst_n,
  ckt_if.slave  bus
);

  logic              r_a, r_b, r_c, r_d, r_e, r_f, r_v1;
  logic              r_w, r_w_valid;
  logic [RESP_W-1:0] r_resp;

  // Each cone net is kept separate so faults can be forced on it individually.
  logic              w_n1, w_n2, w_n3, w_n4, w_wn;
  logic [RESP_W-1:0] w_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= 1'b0;
      r_b  <= 1'b0;
      r_c  <= 1'b0;
      r_d  <= 1'b0;
      r_e  <= 1'b0;
      r_f  <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      r_a  <= bus.a;
      r_b  <= bus.b;
      r_c  <= bus.c;
      r_d  <= bus.d;
      r_e  <= bus.e;
      r_f  <= bus.f;
      r_v1 <= bus.in_valid;
    end
  end

  assign w_n1   = r_a & r_b;
  assign w_n2   = r_c & r_d;
  assign w_n3   = r_e | r_f;
  assign w_n4   = w_n1 | w_n2;
  assign w_wn   = w_n4 ^ w_n3;
  assign w_resp = {w_n1, w_n2, w_n3, w_wn};

  // Result and response word only advance on a valid sample; valid always tracks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
      r_resp    <= {RESP_W{1'b0}};
    end else begin
      r_w_valid <= r_v1;
      if (r_v1) begin
        r_w    <= w_wn;
        r_resp <= w_resp;
      end else begin
        r_w    <= r_w;
        r_resp <= r_resp;
      end
    end
  end

  ckt_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_w_valid),
    .clr   (bus.sig_clr),
    .din   (r_resp),
    .sig   (bus.sig)
  );

  assign bus.w       = r_w;
  assign bus.w_valid = r_w_valid;

endmodule

// File: tb/tb_ckt.sv
// Directed self-checking bench for ckt: reset, truth table, signature, gating,
// clear priority, mid-stream reset and a forced fault on n1.
module tb_ckt;
  import ckt_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [15:0] model_sig;

  ckt_if #(.SIG_W(16)) bus ();

  ckt #(.SIG_W(16), .POLY(16'h1021)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [3:0] r);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {12'd0, r};
  endfunction

  task automatic apply(input logic [5:0] v, input logic val, input logic clr);
    @(negedge clk);
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = v;
    bus.in_valid = val;
    bus.sig_clr  = clr;
  endtask

  logic [5:0] dir_vec [6];
  logic       dir_exp [6];

  initial begin
    logic [3:0] r;
    n_vec = 0;
    n_err = 0;
    dir_vec = '{6'b000000, 6'b110000, 6'b000010, 6'b110010, 6'b001100, 6'b111111};
    dir_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with every input high
    rst_n = 1'b0;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = 6'b111111;
    bus.in_valid = 1'b1;
    bus.sig_clr  = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.w !== 1'b0) begin n_err++; $error("FAIL rst_w: observed %0h expected 0", bus.w); end
    n_vec++; if (bus.w_valid !== 1'b0) begin n_err++; $error("FAIL rst_wv: observed %0h expected 0", bus.w_valid); end
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL rst_sig: observed %0h expected 0", bus.sig); end
    apply(6'b000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w_valid !== 1'b0) begin n_err++; $error("FAIL post_rst_wv: observed %0h expected 0", bus.w_valid); end
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL post_rst_sig: observed %0h expected 0", bus.sig); end

    // Signature from reset: 110000 then 000010
    apply(6'b110000, 1'b1, 1'b0);
    apply(6'b000010, 1'b1, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w !== 1'b1) begin n_err++; $error("FAIL sig_w0: observed %0h expected 1", bus.w); end
    n_vec++; if (bus.w_valid !== 1'b1) begin n_err++; $error("FAIL sig_wv0: observed %0h expected 1", bus.w_valid); end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w !== 1'b1) begin n_err++; $error("FAIL sig_w1: observed %0h expected 1", bus.w); end
    n_vec++; if (bus.sig !== 16'h0009) begin n_err++; $error("FAIL sig_first: observed %0h expected 0009", bus.sig); end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== 16'h0011) begin n_err++; $error("FAIL sig_second: observed %0h expected 0011", bus.sig); end
    n_vec++; if (bus.w_valid !== 1'b0) begin n_err++; $error("FAIL hold_wv: observed %0h expected 0", bus.w_valid); end
    n_vec++; if (bus.w !== 1'b1) begin n_err++; $error("FAIL hold_w: observed %0h expected 1", bus.w); end

    // Invalid 110000 is not flagged or compacted
    apply(6'b110000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w !== 1'b1) begin n_err++; $error("FAIL gate_w: observed %0h expected 1", bus.w); end
    n_vec++; if (bus.w_valid !== 1'b0) begin n_err++; $error("FAIL gate_wv: observed %0h expected 0", bus.w_valid); end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== 16'h0011) begin n_err++; $error("FAIL gate_sig: observed %0h expected 0011", bus.sig); end

    // Clear in the same cycle as a valid response
    apply(6'b110000, 1'b1, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b1);
    n_vec++; if (bus.w_valid !== 1'b1) begin n_err++; $error("FAIL clr_wv: observed %0h expected 1", bus.w_valid); end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL clr_sig: observed %0h expected 0", bus.sig); end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL clr_sig_hold: observed %0h expected 0", bus.sig); end

    // Hand-computed truth-table rows, back to back
    model_sig = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        apply(dir_vec[i], 1'b1, 1'b0);
        r = ckt_eval(dir_vec[i][5], dir_vec[i][4], dir_vec[i][3],
                     dir_vec[i][2], dir_vec[i][1], dir_vec[i][0]);
        model_sig = misr_model(model_sig, r);
      end else begin
        apply(6'b000000, 1'b0, 1'b0);
      end
      if (i >= 2) begin
        n_vec++; if (bus.w !== dir_exp[i-2]) begin n_err++; $error("FAIL dir_w: observed %0h expected %0h", bus.w, dir_exp[i-2]); end
        n_vec++; if (bus.w_valid !== 1'b1) begin n_err++; $error("FAIL dir_wv: observed %0h expected 1", bus.w_valid); end
      end
    end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== model_sig) begin n_err++; $error("FAIL dir_sig: observed %0h expected %0h", bus.sig, model_sig); end

    // Exhaustive 64 vectors against the shared evaluation function
    for (int i = 0; i < 66; i++) begin
      logic [5:0] v;
      logic [5:0] pv;
      if (i < 64) begin
        v = 6'(i);
        apply(v, 1'b1, 1'b0);
        r = ckt_eval(v[5], v[4], v[3], v[2], v[1], v[0]);
        model_sig = misr_model(model_sig, r);
      end else begin
        apply(6'b000000, 1'b0, 1'b0);
      end
      if (i >= 2) begin
        pv = 6'(i - 2);
        r = ckt_eval(pv[5], pv[4], pv[3], pv[2], pv[1], pv[0]);
        n_vec++; if (bus.w !== r[0]) begin n_err++; $error("FAIL tt_w: observed %0h expected %0h", bus.w, r[0]); end
      end
    end
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.sig !== model_sig) begin n_err++; $error("FAIL tt_sig: observed %0h expected %0h", bus.sig, model_sig); end

    // Mid-stream reset discards in-flight vectors
    apply(6'b111100, 1'b1, 1'b0);
    apply(6'b110000, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.w !== 1'b0) begin n_err++; $error("FAIL mid_rst_w: observed %0h expected 0", bus.w); end
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL mid_rst_sig: observed %0h expected 0", bus.sig); end
    apply(6'b000000, 1'b0, 1'b0);
    rst_n = 1'b1;
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w_valid !== 1'b0) begin n_err++; $error("FAIL mid_rst_wv: observed %0h expected 0", bus.w_valid); end
    n_vec++; if (bus.sig !== 16'h0000) begin n_err++; $error("FAIL mid_rst_sig2: observed %0h expected 0", bus.sig); end

    // Stuck-at-0 on n1 flips the result of 110000
    force dut.w_n1 = 1'b0;
    apply(6'b110000, 1'b1, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w !== 1'b0) begin n_err++; $error("FAIL fault_w: observed %0h expected 0", bus.w); end
    n_vec++; if (bus.w_valid !== 1'b1) begin n_err++; $error("FAIL fault_wv: observed %0h expected 1", bus.w_valid); end
    release dut.w_n1;
    apply(6'b110000, 1'b1, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    apply(6'b000000, 1'b0, 1'b0);
    n_vec++; if (bus.w !== 1'b1) begin n_err++; $error("FAIL golden_w: observed %0h expected 1", bus.w); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
